// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the single-register Wishbone GPIO block.
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 16;
  localparam int DATA_LSB      = 0;
  localparam int DIR_LSB       = 16;

  localparam logic [GPIO_MAX_PINS-1:0] OUT_RST = '0;
  localparam logic [GPIO_MAX_PINS-1:0] DIR_RST = '0;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Merge one 16-bit register half with write data, one byte lane per sel bit.
  function automatic logic [GPIO_MAX_PINS-1:0] lane_merge(
    input logic [GPIO_MAX_PINS-1:0] cur,
    input logic [GPIO_MAX_PINS-1:0] wdat,
    input logic [1:0]               sel
  );
    lane_merge = cur;
    if (sel[0]) lane_merge[7:0]  = wdat[7:0];
    if (sel[1]) lane_merge[15:8] = wdat[15:8];
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-pin two-flop synchronizer for asynchronous pad inputs.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int W = GPIO_MAX_PINS
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_wb.sv
// Wishbone slave exposing one GPIO register: pin data in [15:0], direction in [31:16].
module gpio_wb
  import gpio_pkg::*;
#(
  parameter int N = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  inout  wire  [N-1:0] gpio_io
);

  wb_req_t req;
  logic [N-1:0] out_q, dir_q, in_sync;
  logic [GPIO_MAX_PINS-1:0] out_w, dir_w, in_w, out_nxt, dir_nxt;
  logic [31:0] rd_data;
  logic acc, wr_en, rd_en;

  assign req = '{stb: wb_stb_i, we: wb_we_i, sel: wb_sel_i, dat: wb_dat_i};

  // A held strobe alternates ack; only the non-ack cycle is a new access.
  assign acc   = req.stb & ~wb_ack_o;
  assign wr_en = acc & req.we;
  assign rd_en = acc & ~req.we;

  // Work at full register width; bits at/above N are dropped on store and read as 0.
  assign out_w = GPIO_MAX_PINS'(out_q);
  assign dir_w = GPIO_MAX_PINS'(dir_q);
  assign in_w  = GPIO_MAX_PINS'(in_sync);

  assign out_nxt = lane_merge(out_w, req.dat[DATA_LSB +: GPIO_MAX_PINS], req.sel[1:0]);
  assign dir_nxt = lane_merge(dir_w, req.dat[DIR_LSB  +: GPIO_MAX_PINS], req.sel[3:2]);

  always_comb begin
    rd_data = '0;
    rd_data[DATA_LSB +: GPIO_MAX_PINS] = in_w;
    rd_data[DIR_LSB  +: GPIO_MAX_PINS] = dir_w;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      out_q    <= OUT_RST[N-1:0];
      dir_q    <= DIR_RST[N-1:0];
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      if (wr_en) begin
        out_q <= out_nxt[N-1:0];
        dir_q <= dir_nxt[N-1:0];
      end
      if (rd_en) wb_dat_o <= rd_data;
    end
  end

  // Output pins are also read back through the synchronizer, so reads show the real pad level.
  gpio_sync #(.W(N)) u_sync (
    .clk_i (wb_clk_i),
    .rst_n (wb_rst_i),
    .d     (gpio_io),
    .q     (in_sync)
  );

  for (genvar i = 0; i < N; i++) begin : g_pad
    assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_wb.sv
// Directed + randomized bench for gpio_wb; a 16-pin and a 5-pin instance share one bus.
module tb_gpio_wb;

  localparam logic [1:0][15:0] MASK = {16'h001F, 16'hFFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, we, stb;
  logic [3:0]  sel;
  logic [31:0] dat_i, dat_a, dat_b;
  logic        ack_a, ack_b;
  wire  [15:0] pad_a;
  wire  [4:0]  pad_b;

  // External pad drivers: the bench drives a pin only while the model says it is an input.
  logic [1:0][15:0] ext, ext_en;

  for (genvar i = 0; i < 16; i++) begin : g_pa
    assign pad_a[i] = ext_en[0][i] ? ext[0][i] : 1'bz;
  end
  for (genvar i = 0; i < 5; i++) begin : g_pb
    assign pad_b[i] = ext_en[1][i] ? ext[1][i] : 1'bz;
  end

  gpio_wb #(.N(16)) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_dat_i(dat_i), .wb_dat_o(dat_a),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack_a), .gpio_io(pad_a)
  );
  gpio_wb #(.N(5)) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_dat_i(dat_i), .wb_dat_o(dat_b),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack_b), .gpio_io(pad_b)
  );

  // Reference model: register contents, pad history (two edges deep) and bus response.
  logic [1:0][15:0] out_m, dir_m, seen1, seen2;
  logic [1:0][31:0] dat_m;
  logic             ack_m;
  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pad_exp(input int k);
    return ((dir_m[k] & out_m[k]) | (~dir_m[k] & ext[k])) & MASK[k];
  endfunction

  task automatic model_edge();
    logic        accept;
    logic [31:0] w;
    logic [15:0] pin;
    accept = rst_n && stb && !ack_m;
    for (int k = 0; k < 2; k++) begin
      pin = pad_exp(k);
      if (!rst_n) begin
        out_m[k] = '0; dir_m[k] = '0; seen1[k] = '0; seen2[k] = '0; dat_m[k] = '0;
      end else begin
        if (accept && !we) dat_m[k] = {dir_m[k], seen2[k]};
        if (accept && we) begin
          w = {dir_m[k], out_m[k]};
          for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat_i[8*b +: 8];
          out_m[k] = w[15:0]  & MASK[k];
          dir_m[k] = w[31:16] & MASK[k];
        end
        seen2[k] = seen1[k];
        seen1[k] = pin;
      end
    end
    ack_m = accept;
  endtask

  // One clock: model the edge, check the bus, then retarget external drivers and check pads.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack_a", {31'b0, ack_a}, {31'b0, ack_m});
    chk("ack_b", {31'b0, ack_b}, {31'b0, ack_m});
    chk("dat_a", dat_a, dat_m[0]);
    chk("dat_b", dat_b, dat_m[1]);
    @(negedge clk);
    ext_en[0] = ~dir_m[0];
    ext_en[1] = ~dir_m[1] & MASK[1];
    #1;
    chk("pad_a", {16'b0, pad_a}, {16'b0, pad_exp(0)});
    chk("pad_b", {27'b0, pad_b}, {16'b0, pad_exp(1)});
  endtask

  task automatic access(input logic w, input logic [3:0] s, input logic [31:0] d);
    stb = 1'b1; we = w; sel = s; dat_i = d;
    tick();
    stb = 1'b0; we = 1'b0;
    tick();
  endtask

  logic [5:0] pat;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; dat_i = '0;
    ext = '0; ext_en = {MASK[1], MASK[0]};
    out_m = '0; dir_m = '0; seen1 = '0; seen2 = '0; dat_m = '0; ack_m = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;

    // Read straight out of reset
    stb = 1'b1; we = 1'b0;
    tick();
    chk("rst_rd_ack", {31'b0, ack_a}, 32'd1);
    chk("rst_rd_dat", dat_a, 32'h0000_0000);
    stb = 1'b0;
    tick();

    // Low byte becomes output, upper byte driven externally
    access(1'b1, 4'b1111, 32'h00FF_00A5);
    chk("wr_pad_lo", {24'b0, pad_a[7:0]}, 32'hA5);
    ext[0] = 16'h3C00;
    tick();
    tick();
    stb = 1'b1;
    tick();
    chk("rd_3ca5", dat_a, 32'h00FF_3CA5);
    stb = 1'b0;
    tick();

    // Direction-only write leaves out untouched
    access(1'b1, 4'b1100, 32'hFFFF_1234);
    tick();
    tick();
    stb = 1'b1;
    tick();
    chk("rd_dir_only", dat_a, 32'hFFFF_00A5);
    stb = 1'b0;
    tick();
    chk("all_out_pad", {16'b0, pad_a}, 32'h0000_00A5);

    // Synchronizer latency on an input pin
    access(1'b1, 4'b1100, 32'h0000_0000);
    ext[0] = 16'h0000;
    repeat (3) tick();
    ext[0] = 16'h0001;
    tick();
    stb = 1'b1;
    tick();
    chk("sync_early", {31'b0, dat_a[0]}, 32'd0);
    stb = 1'b0;
    tick();
    stb = 1'b1;
    tick();
    chk("sync_late", {31'b0, dat_a[0]}, 32'd1);
    stb = 1'b0;
    tick();

    // Held strobe alternates ack
    pat = 6'b101010;
    stb = 1'b1; we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("ack_pat", {31'b0, ack_a}, {31'b0, pat[i]});
      tick();
    end
    stb = 1'b0;
    tick();

    // Reset coinciding with an accepted write, then access right after release
    access(1'b1, 4'b0011, 32'h0000_5A5A);
    stb = 1'b1; we = 1'b1; sel = 4'hF; dat_i = 32'hFFFF_FFFF; rst_n = 1'b0;
    tick();
    chk("rst_wr_ack", {31'b0, ack_a}, 32'd0);
    rst_n = 1'b1; we = 1'b0;
    tick();
    chk("post_rst_ack", {31'b0, ack_a}, 32'd1);
    chk("post_rst_dir", {16'b0, dat_a[31:16]}, 32'd0);
    stb = 1'b0;
    tick();

    // Byte lanes beyond N on the narrow instance must stay clear
    access(1'b1, 4'b1111, 32'hFFFF_FFFF);
    stb = 1'b1;
    tick();
    chk("narrow_dir", {16'b0, dat_b[31:16]}, 32'h0000_001F);
    stb = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      stb    = ($urandom_range(0, 2) != 0);
      we     = $urandom_range(0, 1);
      sel    = 4'($urandom);
      dat_i  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        ext[0] = 16'($urandom);
        ext[1] = 16'($urandom) & MASK[1];
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
